// File: rtl/conv_window_feeder.sv
// Raster-stream to 2x5 convolution window feeder with KY-1 rows of line memory.
// Optional build macro WIN_COUNT_EN adds a 16-bit per-frame window counter output.
module conv_window_feeder #(
  parameter int WL     = 16,
  parameter int WIDTH  = 166,
  parameter int HEIGHT = 586,
  parameter int KX     = 2,
  parameter int KY     = 5,
  parameter int SY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic signed [WL-1:0] in_data,
  output logic                 in_ready,
  output logic                 win_valid,
  output logic [10*WL-1:0]     win_data,
  output logic                 frame_done,
  output logic                 busy,
`ifdef WIN_COUNT_EN
  output logic [15:0]          win_count,
`endif
  output logic [1:0]           dbg_state
);

  localparam int CW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW    = (SY     > 1) ? $clog2(SY)     : 1;
  localparam int SLOTS = KY - 1;

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready.
  // The window output has no ready; win_valid is a single-cycle enable strobe.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic [1:0]          slot_q, slot_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [5*WL-1:0]     prev_col_q, prev_col_d;
  logic                win_valid_q, win_valid_d;
  logic [10*WL-1:0]    win_data_q, win_data_d;
`ifdef WIN_COUNT_EN
  logic [15:0]         win_count_q, win_count_d;
`endif

  logic [WL-1:0]       mem [SLOTS][WIDTH];
  logic [5*WL-1:0]     cur_col;
  logic                accept, last, emit, frame_start;

  assign frame_start = (state_q == S_IDLE) && start;
  assign accept      = in_valid && (state_q == S_ACTIVE);
  assign last        = accept && (row_q == RW'(HEIGHT - 1)) && (col_q == CW'(WIDTH - 1));
  assign emit        = accept && (row_q >= RW'(KY - 1)) && (phase_q == '0) &&
                       (col_q >= CW'(KX - 1));

  // Slot slot_q still holds row r-4 at this column until the write below lands,
  // so rotating from slot_q yields rows r-4..r-1 oldest first.
  always_comb begin
    cur_col = '0;
    for (int k = 0; k < SLOTS; k++) begin
      cur_col[WL*k +: WL] = mem[slot_q + 2'(k)][col_q];
    end
    cur_col[WL*SLOTS +: WL] = in_data;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[slot_q][col_q] <= in_data;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACTIVE;
      S_ACTIVE: if (last)  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready   = (state_q == S_ACTIVE);
    busy       = (state_q == S_ACTIVE);
    frame_done = (state_q == S_DONE);
    dbg_state  = state_q;
  end

  // Raster counters; phase tracks (row - (KY-1)) mod SY once past the warm-up rows.
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    slot_d  = slot_q;
    phase_d = phase_q;
    if (frame_start) begin
      row_d   = '0;
      col_d   = '0;
      slot_d  = '0;
      phase_d = '0;
    end else if (accept) begin
      if (col_q == CW'(WIDTH - 1)) begin
        col_d  = '0;
        row_d  = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
        slot_d = (slot_q == 2'(SLOTS - 1)) ? 2'd0 : slot_q + 2'd1;
        if (row_q < RW'(KY - 1)) begin
          phase_d = '0;
        end else begin
          phase_d = (phase_q == PW'(SY - 1)) ? '0 : phase_q + PW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    prev_col_d  = accept ? cur_col : prev_col_q;
    win_valid_d = emit;
    win_data_d  = emit ? {cur_col, prev_col_q} : win_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q       <= '0;
      col_q       <= '0;
      slot_q      <= '0;
      phase_q     <= '0;
      prev_col_q  <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      slot_q      <= slot_d;
      phase_q     <= phase_d;
      prev_col_q  <= prev_col_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;

`ifdef WIN_COUNT_EN
  // Counts alongside the registered strobe so the final value is visible with frame_done.
  always_comb begin
    win_count_d = win_count_q;
    if (frame_start) begin
      win_count_d = '0;
    end else if (emit) begin
      win_count_d = win_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_count_q <= '0;
    end else begin
      win_count_q <= win_count_d;
    end
  end

  assign win_count = win_count_q;
`endif

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder on a 4x7 frame with sample = 16*row+col.
// Expected windows are queued as samples are driven and popped when win_valid fires.
module tb_conv_window_feeder;

  localparam int WL = 16;
  localparam int W  = 4;
  localparam int H  = 7;
  localparam int DW = 10 * WL;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic                 in_valid;
  logic signed [WL-1:0] in_data;
  logic                 in_ready;
  logic                 win_valid;
  logic [DW-1:0]        win_data;
  logic                 frame_done;
  logic                 busy;
  logic [1:0]           dbg_state;
`ifdef WIN_COUNT_EN
  logic [15:0]          win_count;
`endif

  conv_window_feeder #(
    .WL(WL), .WIDTH(W), .HEIGHT(H), .KX(2), .KY(5), .SY(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .frame_done (frame_done),
    .busy       (busy),
`ifdef WIN_COUNT_EN
    .win_count  (win_count),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_exp;
  int n_tests = 0;
  int n_fail  = 0;
  int win_seen  = 0;
  int done_seen = 0;
  bit dot_pending = 1'b0;
  int wts[10] = '{1, 2, 3, 0, 0, 1, 2, 3, 0, 0};

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_win(input int r, input int c);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < 5; k++) begin
      w[WL*k +: WL]     = WL'(16 * (r - 4 + k) + c - 1);
      w[WL*(k+5) +: WL] = WL'(16 * (r - 4 + k) + c);
    end
    return w;
  endfunction

  // Scoreboard: pop on each window strobe
  always @(negedge clk) begin
    if (!reset && win_valid) begin
      win_seen++;
      check_int("window_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check_word("window_data", win_data, exp_q.pop_front());
      end
      if (dot_pending) begin
        int acc;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
          acc += int'($signed(win_data[WL*k +: WL])) * wts[k];
        end
        check_int("first_window_conv", acc, 262);
        dot_pending = 1'b0;
      end
    end
    if (!reset && frame_done) begin
      done_seen++;
    end
  end

  // Driver tasks
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_bit("start_in_ready", in_ready, 1'b1);
    check_bit("start_busy", busy, 1'b1);
    check_int("start_state", int'(dbg_state), 1);
`ifdef WIN_COUNT_EN
    check_int("start_win_count", int'(win_count), 0);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check_bit({tag, "_in_ready"}, in_ready, 1'b0);
    check_bit({tag, "_win_valid"}, win_valid, 1'b0);
    check_bit({tag, "_frame_done"}, frame_done, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_int({tag, "_state"}, int'(dbg_state), 0);
  endtask

  task automatic send_frame(input bit toggle, input int abort_r, input int abort_c,
                            input bit start_mid);
    int  w0, d0, nwin;
    bit  emit;
    w0 = win_seen;
    d0 = done_seen;
    nwin = 0;
    dot_pending = 1'b1;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == abort_r && c == abort_c) begin
          in_valid = 1'b0;
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          return;
        end
        if (toggle) begin
          in_valid = 1'b0;
          @(negedge clk);
          check_bit("gap_no_window", win_valid, 1'b0);
          check_bit("gap_in_ready", in_ready, 1'b1);
          check_word("gap_win_data_hold", win_data, last_exp);
        end
        in_valid = 1'b1;
        in_data  = WL'(16 * r + c);
        start    = start_mid && (r == 2) && (c == 1);
        check_bit("active_in_ready", in_ready, 1'b1);
        emit = (r >= 4) && ((r - 4) % 2 == 0) && (c >= 1);
        if (emit) begin
          exp_q.push_back(model_win(r, c));
          last_exp = model_win(r, c);
          nwin++;
        end
        @(negedge clk);
        start = 1'b0;
        check_bit("win_valid_timing", win_valid, emit);
      end
    end
    in_valid = 1'b0;
    check_bit("frame_done_with_last", frame_done, 1'b1);
`ifdef WIN_COUNT_EN
    check_int("win_count_at_done", int'(win_count), nwin);
`endif
    @(negedge clk);
    check_idle_outputs("post_frame");
    check_int("windows_per_frame", win_seen - w0, 6);
    check_int("frame_done_pulses", done_seen - d0, 1);
    check_int("queue_drained", exp_q.size(), 0);
`ifdef WIN_COUNT_EN
    repeat (3) @(negedge clk);
    check_int("win_count_hold", int'(win_count), nwin);
`endif
  endtask

  // Directed sequence
  initial begin
    int d0;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    last_exp = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check_word("reset_win_data", win_data, '0);
    reset = 1'b0;
    @(negedge clk);

    // Samples offered while idle must be ignored
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = WL'($urandom_range(0, 65535));
      @(negedge clk);
      check_idle_outputs("idle_valid");
    end
    in_valid = 1'b0;

    // Continuous stream
    pulse_start();
    send_frame(1'b0, -1, -1, 1'b0);

    // in_valid toggling every cycle
    pulse_start();
    send_frame(1'b1, -1, -1, 1'b0);

    // Abort at sample (5,2)
    pulse_start();
    d0 = done_seen;
    send_frame(1'b0, 5, 2, 1'b0);
    last_exp = '0;
    check_idle_outputs("abort");
    check_word("abort_win_data", win_data, '0);
    repeat (4) @(negedge clk);
    check_int("abort_no_done", done_seen - d0, 0);
    check_int("abort_queue_empty", exp_q.size(), 0);

    // Fresh frame after abort, with a stray start pulse mid-frame
    pulse_start();
    send_frame(1'b0, -1, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Stream-to-window front end for the stage-1 convolution.
- Accepts a spectrogram frame as a raster-order 16-bit sample stream, buffers KY-1 previous rows in line memory, and emits each 2x5 kernel window (stride x1, y2) as 10 parallel words plus an enable strobe.
- Drives the convolution stage's enable and datain1..datain10 inputs directly; that stage has no backpressure.

Parameters:
- WL, 16: sample word length.
- WIDTH, 166: samples per row (x).
- HEIGHT, 586: rows per frame (y).
- KX, 2: kernel width. The datapath is fixed at 2.
- KY, 5: kernel height. The datapath is fixed at 5.
- SY, 2: vertical stride. Horizontal stride is fixed at 1.

Ports:
- clk  in  1  clock
- reset  in  1  sync reset, active-high
- start  in  1  one-cycle pulse, begins a frame
- in_valid  in  1  input sample valid
- in_data  in  WL  signed input sample
- in_ready  out  1  feeder accepts a sample this cycle
- win_valid  out  1  window valid; drives conv enable
- win_data  out  10*WL  window words; word k at [WL*k+WL-1:WL*k] drives datain(k+1)
- frame_done  out  1  one-cycle pulse at end of frame
- busy  out  1  high while a frame is in progress

Behaviour:
- Reset is synchronous and active-high; clock is clk.
- Reset values: in_ready=0, win_valid=0, win_data=0, frame_done=0, busy=0, state=IDLE, row=0, col=0.
- Line memory contents are not cleared on reset.
- States:
  - IDLE: leaves on start=1 to ACTIVE.
  - ACTIVE: busy=1, in_ready=1. Leaves to DONE on acceptance of sample (HEIGHT-1, WIDTH-1).
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- A sample is accepted when in_valid & in_ready.
- col increments per accept and wraps WIDTH-1 -> 0, which increments row.
- Accepted sample (r,c) is written to line memory slot r mod (KY-1), column c. The row-slot pointer rotates.
- Window column c is formed from memory rows r-4..r-1 at column c plus the new sample; it is stored in a previous-column register for the next accept.
- A window is emitted for accept (r,c) iff all of the following hold:
  - r >= KY-1
  - (r-(KY-1)) mod SY == 0
  - c >= KX-1
- Window ordering:
  - words 0..4 = rows r-4..r of column c-1
  - words 5..9 = rows r-4..r of column c
- Latency: win_valid and win_data are registered, 1 cycle after the accepting edge.
- win_valid is high for exactly one cycle per window. win_data holds its last value when win_valid=0.
- The final window's win_valid coincides with the frame_done cycle.
- in_valid gaps stall counters and emit nothing; there is no timeout.
- Default window count: (WIDTH-1)*((HEIGHT-KY)/SY+1) = 165*291 = 48015.
- The previous-column register is invalid at c=0, so no window is emitted at c=0.
- in_data is ignored in IDLE and DONE because in_ready=0.
- start is ignored outside IDLE.
- Reset mid-frame aborts: outputs return to reset values next cycle and no frame_done is issued. A following start begins a fresh frame at (0,0).
- Counter widths are clog2(WIDTH) and clog2(HEIGHT). No arithmetic is performed on samples.

Optional Feature:
- Macro: WIN_COUNT_EN.
- Defined: adds output win_count (16 bits).
  - Clears on start and on reset.
  - Increments on each win_valid cycle.
  - Holds its final value through IDLE until the next start.
  - The default frame ends at 48015.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- All scenarios use WIDTH=4, HEIGHT=7, sample = 16*row+col, in_valid held high.
- Start, stream the full frame -> exactly 6 win_valid pulses, at (r,c) = (4,1),(4,2),(4,3),(6,1),(6,2),(6,3). Row 5 emits none. frame_done coincides with the 6th pulse.
- First window -> words 0..9 = 0,16,32,48,64,1,17,33,49,65. Feeding these to conv weights 1,2,3,0,0,1,2,3,0,0 gives dataout=262.
- Toggle in_valid 1/0 every cycle over the full frame -> identical window contents and count. in_ready stays 1 while ACTIVE.
- Assert reset at sample (5,2), then start and a full frame -> no frame_done for the aborted frame. The new frame's first window is identical to scenario 2.
- Pulse start in ACTIVE, and in_valid while IDLE -> no effect: in_ready=0 and counters unchanged.
- With WIN_COUNT_EN, default params, full frame -> win_count=48015 at frame_done. It holds until the next start.
